// File: rtl/seg7_reg_display.sv
// Time-multiplexed 8-digit hex display for a 32-bit register word, common-anode.
// Input is snapshotted once per scan frame so a digit never shows a mix of old and new nibbles.
module seg7_reg_display #(
    parameter int DIG_PERIOD = 100000,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] data,
    input  logic [7:0]  dp_mask,
    input  logic        enable,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int            PW       = (DIG_PERIOD > 1) ? $clog2(DIG_PERIOD) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIG_PERIOD - 1);

    logic [PW-1:0] prescaler;
    logic          tick;
    logic          frame_end;
    logic [2:0]    idx;
    logic [31:0]   shadow_data;
    logic [7:0]    shadow_dp;

    logic [7:0]    an_p0;
    logic [6:0]    seg_p0;
    logic          dp_p0;
    logic [3:0]    nib_p0;
    logic          blank_p0;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick      = (prescaler == PRE_LAST);
    assign frame_end = tick && (idx == 3'd7);

    // Scan timing and frame snapshot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prescaler   <= '0;
            idx         <= 3'd0;
            shadow_data <= 32'd0;
            shadow_dp   <= 8'd0;
            frame_tick  <= 1'b0;
        end else begin
            prescaler  <= tick ? '0 : prescaler + PW'(1);
            frame_tick <= frame_end;
            if (tick) begin
                idx <= idx + 3'd1;
            end
            if (frame_end) begin
                shadow_data <= data;
                shadow_dp   <= dp_mask;
            end
        end
    end

    // A digit is blank when it and every nibble above it are zero; digit 0 always shows.
    always_comb begin
        nib_p0   = shadow_data[{idx, 2'b00} +: 4];
        blank_p0 = BLANK_LZ && (idx != 3'd0) && ((shadow_data >> {idx, 2'b00}) == 32'd0);
        an_p0    = 8'hFF;
        seg_p0   = 7'h7F;
        dp_p0    = 1'b1;
        if (enable) begin
            an_p0  = ~(8'd1 << idx);
            seg_p0 = blank_p0 ? 7'h7F : hex_to_seg(nib_p0);
            dp_p0  = ~shadow_dp[idx];
        end
    end

    // Registered display drive
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_p0;
            seg <= seg_p0;
            dp  <= dp_p0;
        end
    end

endmodule

// File: tb/tb_seg7_reg_display.sv
// Scoreboard bench: three display instances (two scan periods, both blanking modes)
// checked every cycle against a cycle-count based reference of the scan.
module tb_seg7_reg_display;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } out_t;

    typedef struct packed {
        out_t o0;
        out_t o1;
        out_t o2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] data = 32'd0;
    logic [7:0]  dp_mask = 8'd0;
    logic        enable = 1'b1;

    logic [7:0] an0, an1, an2;
    logic [6:0] seg0, seg1, seg2;
    logic       dp0, dp1, dp2;
    logic       ft0, ft1, ft2;

    int errors = 0;
    int checks = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg7_reg_display #(.DIG_PERIOD(4), .BLANK_LZ(1'b0)) u_dut0 (
        .clk(clk), .rstn(rstn), .data(data), .dp_mask(dp_mask), .enable(enable),
        .an(an0), .seg(seg0), .dp(dp0), .frame_tick(ft0));
    seg7_reg_display #(.DIG_PERIOD(4), .BLANK_LZ(1'b1)) u_dut1 (
        .clk(clk), .rstn(rstn), .data(data), .dp_mask(dp_mask), .enable(enable),
        .an(an1), .seg(seg1), .dp(dp1), .frame_tick(ft1));
    seg7_reg_display #(.DIG_PERIOD(5), .BLANK_LZ(1'b1)) u_dut2 (
        .clk(clk), .rstn(rstn), .data(data), .dp_mask(dp_mask), .enable(enable),
        .an(an2), .seg(seg2), .dp(dp2), .frame_tick(ft2));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Display output after an edge, given k edges since reset release before that edge.
    function automatic out_t expect_out(input int p, input bit blz, input int k,
                                        input logic [31:0] sd, input logic [7:0] sdp,
                                        input logic en);
        out_t o;
        int   digit;
        int   msd;
        digit = (k / p) % 8;
        msd   = 0;
        for (int i = 0; i < 8; i++) begin
            if (sd[4*i +: 4] != 4'h0) msd = i;
        end
        o.ft  = ((k % (8 * p)) == (8 * p - 1));
        o.an  = 8'hFF;
        o.seg = 7'h7F;
        o.dp  = 1'b1;
        if (en) begin
            o.an  = ~(8'd1 << digit);
            o.seg = (blz && digit > msd) ? 7'h7F : hex_tab[sd[4*digit +: 4]];
            o.dp  = ~sdp[digit];
        end
        return o;
    endfunction

    // Reference model
    int          k = 0;
    int          per [3] = '{4, 4, 5};
    bit          blz [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] sh_d [3] = '{32'd0, 32'd0, 32'd0};
    logic [7:0]  sh_dp [3] = '{8'd0, 8'd0, 8'd0};
    exp_t        sb [$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k = 0;
            for (int j = 0; j < 3; j++) begin
                sh_d[j]  = 32'd0;
                sh_dp[j] = 8'd0;
            end
            sb.delete();
        end else begin
            exp_t e;
            e.o0 = expect_out(per[0], blz[0], k, sh_d[0], sh_dp[0], enable);
            e.o1 = expect_out(per[1], blz[1], k, sh_d[1], sh_dp[1], enable);
            e.o2 = expect_out(per[2], blz[2], k, sh_d[2], sh_dp[2], enable);
            sb.push_back(e);
            for (int j = 0; j < 3; j++) begin
                if ((k % (8 * per[j])) == (8 * per[j] - 1)) begin
                    sh_d[j]  = data;
                    sh_dp[j] = dp_mask;
                end
            end
            k++;
        end
    end

    // Monitor
    int ncyc = 0;
    int last_ft = -1;

    always @(negedge clk) begin
        ncyc++;
        if (!rstn) begin
            last_ft = -1;
            check("reset_out0", {an0, seg0, dp0, ft0}, {8'hFF, 7'h7F, 1'b1, 1'b0});
            check("reset_out1", {an1, seg1, dp1, ft1}, {8'hFF, 7'h7F, 1'b1, 1'b0});
            check("reset_out2", {an2, seg2, dp2, ft2}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        end else if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("dut0_out", {an0, seg0, dp0, ft0}, e.o0);
            check("dut1_out", {an1, seg1, dp1, ft1}, e.o1);
            check("dut2_out", {an2, seg2, dp2, ft2}, e.o2);
            if (ft0) begin
                if (last_ft >= 0) check("frame_period", ncyc - last_ft, 32);
                last_ft = ncyc;
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_now(input string name);
        check({name, "_0"}, {an0, seg0, dp0, ft0}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        check({name, "_1"}, {an1, seg1, dp1, ft1}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        check({name, "_2"}, {an2, seg2, dp2, ft2}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    endtask

    initial begin
        run(3);
        #2 rstn = 1'b1;
        data = 32'h1234_5678;
        run(100);
        data = 32'hFFFF_FFFF;
        run(70);
        data = 32'h0000_00A0;
        run(70);
        data = 32'd0;
        run(40);
        dp_mask = 8'h80;
        run(70);
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(50);

        for (int it = 0; it < 40; it++) begin
            data    = $urandom >> $urandom_range(0, 31);
            dp_mask = 8'($urandom);
            enable  = ($urandom_range(0, 3) != 0);
            run($urandom_range(1, 25));
        end
        enable = 1'b1;
        run(20);

        // Asynchronous reset mid-cycle, observed before any clock edge
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_now("async_reset");
        run(3);
        #2 rstn = 1'b1;
        data    = 32'h00C0_FFEE;
        dp_mask = 8'h05;
        run(120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
